// File: rtl/arp_tx_sched_if.sv
// Handshake and frame bus of the ARP transmit scheduler.
// master = scheduler side, slave = receive path / ARP transmitter side.
interface arp_tx_sched_if;
  logic        s_reply_valid;
  logic        s_reply_ready;
  logic [47:0] s_reply_tha;
  logic [31:0] s_reply_tpa;
  logic        s_req_valid;
  logic        s_req_ready;
  logic [31:0] s_req_ip;
  logic        s_resolved_valid;
  logic [31:0] s_resolved_ip;
  logic        m_frame_valid;
  logic        m_frame_ready;
  logic [47:0] m_eth_dest_mac;
  logic [47:0] m_eth_src_mac;
  logic [15:0] m_eth_type;
  logic [15:0] m_arp_htype;
  logic [15:0] m_arp_ptype;
  logic [15:0] m_arp_oper;
  logic [47:0] m_arp_sha;
  logic [31:0] m_arp_spa;
  logic [47:0] m_arp_tha;
  logic [31:0] m_arp_tpa;

  modport master (
    input  s_reply_valid, s_reply_tha, s_reply_tpa,
    output s_reply_ready,
    input  s_req_valid, s_req_ip,
    output s_req_ready,
    input  s_resolved_valid, s_resolved_ip,
    output m_frame_valid,
    input  m_frame_ready,
    output m_eth_dest_mac, m_eth_src_mac, m_eth_type,
    output m_arp_htype, m_arp_ptype, m_arp_oper,
    output m_arp_sha, m_arp_spa, m_arp_tha, m_arp_tpa
  );

  modport slave (
    output s_reply_valid, s_reply_tha, s_reply_tpa,
    input  s_reply_ready,
    output s_req_valid, s_req_ip,
    input  s_req_ready,
    output s_resolved_valid, s_resolved_ip,
    input  m_frame_valid,
    output m_frame_ready,
    input  m_eth_dest_mac, m_eth_src_mac, m_eth_type,
    input  m_arp_htype, m_arp_ptype, m_arp_oper,
    input  m_arp_sha, m_arp_spa, m_arp_tha, m_arp_tpa
  );
endinterface

// File: rtl/arp_tx_sched.sv
// ARP transmit scheduler: strict-priority replies plus one retried lookup request.
// Define ARP_SCHED_RETRY_EN to enable up to RETRY_COUNT transmissions per lookup.
module arp_tx_sched #(
  parameter int RETRY_COUNT    = 4,
  parameter int RETRY_INTERVAL = 1000,
  parameter int TIMER_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [47:0]          local_mac,
  input  logic [31:0]          local_ip,
  arp_tx_sched_if.master       bus,
  output logic                 req_done,
  output logic                 req_error,
  output logic                 busy
);

  localparam int CNT_W = $clog2(RETRY_COUNT + 1);
`ifdef ARP_SCHED_RETRY_EN
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RETRY_COUNT);
`else
  localparam logic [CNT_W-1:0] CNT_INIT = '0;
`endif
  localparam logic [TIMER_WIDTH-1:0] TIMER_LOAD = TIMER_WIDTH'(RETRY_INTERVAL - 1);

  typedef struct packed {
    logic [47:0] dest;
    logic [47:0] src;
    logic [15:0] etype;
    logic [15:0] htype;
    logic [15:0] ptype;
    logic [15:0] oper;
    logic [47:0] sha;
    logic [31:0] spa;
    logic [47:0] tha;
    logic [31:0] tpa;
  } frame_t;

  frame_t                 frame_q, frame_d;
  logic                   valid_q, valid_d;
  logic                   pending_q, pending_d;
  logic [31:0]            ip_q, ip_d;
  logic                   send_due_q, send_due_d;
  logic [CNT_W-1:0]       retry_cnt_q, retry_cnt_d;
  logic [TIMER_WIDTH-1:0] timer_q, timer_d;
  logic                   req_ready_q;
  logic                   done_q, done_d;
  logic                   error_q, error_d;

  logic free, accept, resolve_hit, timer_zero, reply_load, req_load;

  always_comb begin
    free        = !valid_q || bus.m_frame_ready;
    accept      = bus.s_req_valid && req_ready_q;
    resolve_hit = bus.s_resolved_valid && pending_q && (bus.s_resolved_ip == ip_q);
    timer_zero  = pending_q && !send_due_q && (timer_q == '0);
    reply_load  = bus.s_reply_valid && free;
    // A retry expiring this cycle may load immediately, keeping loads exactly one interval apart.
    req_load    = pending_q && !resolve_hit && free && !bus.s_reply_valid &&
                  (send_due_q || (timer_zero && retry_cnt_q != '0));

    pending_d   = pending_q;
    ip_d        = ip_q;
    send_due_d  = send_due_q;
    retry_cnt_d = retry_cnt_q;
    timer_d     = timer_q;
    done_d      = 1'b0;
    error_d     = 1'b0;
    valid_d     = valid_q;
    frame_d     = frame_q;

    if (accept) begin
      pending_d   = 1'b1;
      ip_d        = bus.s_req_ip;
      send_due_d  = 1'b1;
      retry_cnt_d = CNT_INIT;
    end else if (resolve_hit) begin
      pending_d  = 1'b0;
      send_due_d = 1'b0;
      done_d     = 1'b1;
    end else if (timer_zero && retry_cnt_q == '0) begin
      pending_d = 1'b0;
      error_d   = 1'b1;
    end else if (req_load) begin
      send_due_d = 1'b0;
`ifdef ARP_SCHED_RETRY_EN
      retry_cnt_d = retry_cnt_q - CNT_W'(1);
`endif
      timer_d    = TIMER_LOAD;
    end else if (timer_zero) begin
      send_due_d = 1'b1;
    end else if (pending_q && !send_due_q) begin
      timer_d = timer_q - TIMER_WIDTH'(1);
    end

    // Fields only change on a load; valid drops on a handshake with nothing to follow.
    if (reply_load) begin
      valid_d = 1'b1;
      frame_d = '{dest: bus.s_reply_tha, src: local_mac, etype: 16'h0806,
                  htype: 16'h0001, ptype: 16'h0800, oper: 16'd2,
                  sha: local_mac, spa: local_ip,
                  tha: bus.s_reply_tha, tpa: bus.s_reply_tpa};
    end else if (req_load) begin
      valid_d = 1'b1;
      frame_d = '{dest: 48'hFFFF_FFFF_FFFF, src: local_mac, etype: 16'h0806,
                  htype: 16'h0001, ptype: 16'h0800, oper: 16'd1,
                  sha: local_mac, spa: local_ip,
                  tha: 48'h0, tpa: ip_q};
    end else if (bus.m_frame_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_q     <= '0;
      valid_q     <= 1'b0;
      pending_q   <= 1'b0;
      ip_q        <= '0;
      send_due_q  <= 1'b0;
      retry_cnt_q <= '0;
      timer_q     <= '0;
      req_ready_q <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      frame_q     <= frame_d;
      valid_q     <= valid_d;
      pending_q   <= pending_d;
      ip_q        <= ip_d;
      send_due_q  <= send_due_d;
      retry_cnt_q <= retry_cnt_d;
      timer_q     <= timer_d;
      req_ready_q <= !pending_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign bus.s_reply_ready  = free;
  assign bus.s_req_ready    = req_ready_q;
  assign bus.m_frame_valid  = valid_q;
  assign bus.m_eth_dest_mac = frame_q.dest;
  assign bus.m_eth_src_mac  = frame_q.src;
  assign bus.m_eth_type     = frame_q.etype;
  assign bus.m_arp_htype    = frame_q.htype;
  assign bus.m_arp_ptype    = frame_q.ptype;
  assign bus.m_arp_oper     = frame_q.oper;
  assign bus.m_arp_sha      = frame_q.sha;
  assign bus.m_arp_spa      = frame_q.spa;
  assign bus.m_arp_tha      = frame_q.tha;
  assign bus.m_arp_tpa      = frame_q.tpa;
  assign req_done           = done_q;
  assign req_error          = error_q;
  assign busy               = pending_q || valid_q;

endmodule

// File: tb/tb_arp_tx_sched.sv
// Scoreboard bench for arp_tx_sched: expected frames queued by stimulus, checked by a handshake monitor.
module tb_arp_tx_sched;
  localparam int RC = 3;
  localparam int RI = 20;
`ifdef ARP_SCHED_RETRY_EN
  localparam int NTX = RC;
`else
  localparam int NTX = 1;
`endif

  typedef struct packed {
    logic [47:0] dest;
    logic [47:0] src;
    logic [15:0] etype;
    logic [15:0] htype;
    logic [15:0] ptype;
    logic [15:0] oper;
    logic [47:0] sha;
    logic [31:0] spa;
    logic [47:0] tha;
    logic [31:0] tpa;
  } frame_t;

  logic        clk, rst;
  logic [47:0] local_mac;
  logic [31:0] local_ip;
  logic        req_done, req_error, busy;
  arp_tx_sched_if bus();

  arp_tx_sched #(.RETRY_COUNT(RC), .RETRY_INTERVAL(RI), .TIMER_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .local_mac(local_mac), .local_ip(local_ip),
    .bus(bus), .req_done(req_done), .req_error(req_error), .busy(busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;
  int hs_total = 0, done_cnt = 0, err_cnt = 0, done_cyc = -1, err_cyc = -1;
  int hs_cyc[$];
  frame_t exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_frame(input string nm, input frame_t act, input frame_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic frame_t obs_frame();
    return '{dest: bus.m_eth_dest_mac, src: bus.m_eth_src_mac, etype: bus.m_eth_type,
             htype: bus.m_arp_htype, ptype: bus.m_arp_ptype, oper: bus.m_arp_oper,
             sha: bus.m_arp_sha, spa: bus.m_arp_spa, tha: bus.m_arp_tha, tpa: bus.m_arp_tpa};
  endfunction

  function automatic frame_t mk_reply(input logic [47:0] tha, input logic [31:0] tpa,
                                      input logic [47:0] mac, input logic [31:0] ip);
    return '{dest: tha, src: mac, etype: 16'h0806, htype: 16'h0001, ptype: 16'h0800,
             oper: 16'd2, sha: mac, spa: ip, tha: tha, tpa: tpa};
  endfunction

  function automatic frame_t mk_req(input logic [31:0] tip, input logic [47:0] mac,
                                    input logic [31:0] ip);
    return '{dest: 48'hFFFF_FFFF_FFFF, src: mac, etype: 16'h0806, htype: 16'h0001,
             ptype: 16'h0800, oper: 16'd1, sha: mac, spa: ip, tha: 48'h0, tpa: tip};
  endfunction

  // Monitor: frame handshakes and completion pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.m_frame_valid && bus.m_frame_ready) begin
      hs_cyc.push_back(cyc);
      hs_total++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL frame_unexpected got=%h exp=none", obs_frame());
      end else begin
        chk_frame("frame", obs_frame(), exp_q.pop_front());
      end
    end
    if (req_done) begin done_cnt++; done_cyc = cyc; end
    if (req_error) begin err_cnt++; err_cyc = cyc; end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input logic [31:0] ip, output int acc);
    int n = 0;
    while (!bus.s_req_ready && n < 50) begin step(); n++; end
    chk("lookup_ready", bus.s_req_ready, 1);
    bus.s_req_valid = 1'b1;
    bus.s_req_ip    = ip;
    acc = cyc + 1;
    step();
    bus.s_req_valid = 1'b0;
  endtask

  task automatic resolve(input logic [31:0] ip);
    bus.s_resolved_valid = 1'b1;
    bus.s_resolved_ip    = ip;
    step();
    bus.s_resolved_valid = 1'b0;
  endtask

  task automatic wait_hs(input string nm, input int target, input int lim);
    for (int i = 0; i < lim && hs_total < target; i++) step();
    chk(nm, hs_total >= target, 1);
  endtask

  localparam logic [47:0] MAC0 = 48'h02_00_00_00_00_AA;
  localparam logic [31:0] IP0  = 32'h0A00_0001;
  localparam logic [31:0] TIP  = 32'h0A00_0005;

  int acc, bh, bd, be, L, E;
  int hold_bad;
  frame_t f;

  initial begin
    rst = 1'b1;
    local_mac = MAC0;
    local_ip  = IP0;
    bus.s_reply_valid = 0; bus.s_reply_tha = '0; bus.s_reply_tpa = '0;
    bus.s_req_valid = 0; bus.s_req_ip = '0;
    bus.s_resolved_valid = 0; bus.s_resolved_ip = '0;
    bus.m_frame_ready = 1'b1;

    // Reset state
    step(); step();
    chk("rst_valid", bus.m_frame_valid, 0);
    chk_frame("rst_fields", obs_frame(), '0);
    chk("rst_req_ready", bus.s_req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pulses", {req_done, req_error}, 0);
    rst = 1'b0;
    step();
    chk("post_rst_req_ready", bus.s_req_ready, 1);

    // Unresolved lookup: NTX broadcasts RI apart, then one error RI after the last
    bh = hs_total; be = err_cnt; bd = done_cnt;
    for (int i = 0; i < NTX; i++) exp_q.push_back(mk_req(TIP, MAC0, IP0));
    lookup(TIP, acc);
    chk("t1_req_ready_low", bus.s_req_ready, 0);
    chk("t1_busy", busy, 1);
    for (int i = 0; i < 200 && err_cnt == be; i++) step();
    chk("t1_frames", hs_total - bh, NTX);
    for (int i = 0; i < NTX; i++) chk("t1_load_cyc", hs_cyc[bh + i], acc + 1 + RI * i);
    chk("t1_err_cyc", err_cyc, acc + 1 + RI * NTX);
    chk("t1_busy_after", busy, 0);
    chk("t1_req_ready_after", bus.s_req_ready, 1);
    repeat (5) step();
    chk("t1_err_once", err_cnt - be, 1);
    chk("t1_no_done", done_cnt - bd, 0);

    // Resolved 5 cycles after the first frame
    bh = hs_total; be = err_cnt; bd = done_cnt;
    exp_q.push_back(mk_req(TIP, MAC0, IP0));
    lookup(TIP, acc);
    wait_hs("t2_first_frame", bh + 1, 10);
    L = hs_cyc[bh];
    chk("t2_load_cyc", L, acc + 1);
    while (cyc < L + 4) step();
    resolve(TIP);
    chk("t2_req_ready", bus.s_req_ready, 1);
    step();
    chk("t2_done_cyc", done_cyc, L + 5);
    repeat (40) step();
    chk("t2_frames", hs_total - bh, 1);
    chk("t2_done_once", done_cnt - bd, 1);
    chk("t2_no_err", err_cnt - be, 0);

    // Reply competing with a due request: reply first, request back-to-back
    bh = hs_total; bd = done_cnt;
    exp_q.push_back(mk_reply(48'h02_00_00_00_00_01, 32'h0A00_0009, MAC0, IP0));
    exp_q.push_back(mk_req(32'h0A00_0007, MAC0, IP0));
    bus.s_req_valid = 1'b1;
    bus.s_req_ip    = 32'h0A00_0007;
    acc = cyc + 1;
    step();
    bus.s_req_valid   = 1'b0;
    bus.s_reply_valid = 1'b1;
    bus.s_reply_tha   = 48'h02_00_00_00_00_01;
    bus.s_reply_tpa   = 32'h0A00_0009;
    step();
    bus.s_reply_valid = 1'b0;
    wait_hs("t3_frames", bh + 2, 10);
    chk("t3_reply_cyc", hs_cyc[bh], acc + 1);
    chk("t3_req_cyc", hs_cyc[bh + 1], acc + 2);
    resolve(32'h0A00_0007);
    step();
    chk("t3_done", done_cnt - bd, 1);

    // Reply held 50 cycles by a stalled transmitter
    bh = hs_total;
    bus.m_frame_ready = 1'b0;
    f = mk_reply(48'h02_11_22_33_44_55, 32'h0A00_0042, MAC0, IP0);
    exp_q.push_back(f);
    bus.s_reply_valid = 1'b1;
    bus.s_reply_tha   = 48'h02_11_22_33_44_55;
    bus.s_reply_tpa   = 32'h0A00_0042;
    step();
    bus.s_reply_valid = 1'b0;
    local_mac = 48'h02_DE_AD_BE_EF_00;
    hold_bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (obs_frame() !== f || bus.m_frame_valid !== 1'b1 || bus.s_reply_ready !== 1'b0)
        hold_bad++;
      step();
    end
    chk("t4_hold_stable", hold_bad, 0);
    local_mac = MAC0;
    bus.m_frame_ready = 1'b1;
    step();
    chk("t4_handshake", hs_total - bh, 1);
    chk("t4_valid_drop", bus.m_frame_valid, 0);
    chk("t4_reply_ready", bus.s_reply_ready, 1);

    // Resolution on the cycle the final timeout would fire
    bh = hs_total; be = err_cnt; bd = done_cnt;
    for (int i = 0; i < NTX; i++) exp_q.push_back(mk_req(TIP, MAC0, IP0));
    lookup(TIP, acc);
    E = acc + 1 + RI * NTX;
    while (cyc < E - 1) step();
    resolve(TIP);
    step();
    chk("t5_done_cyc", done_cyc, E);
    repeat (5) step();
    chk("t5_done_once", done_cnt - bd, 1);
    chk("t5_no_err", err_cnt - be, 0);
    chk("t5_frames", hs_total - bh, NTX);

    // Reset with a pending lookup and a stalled frame
    bh = hs_total; be = err_cnt; bd = done_cnt;
    bus.m_frame_ready = 1'b0;
    lookup(TIP, acc);
    step();
    chk("t6_valid_pre", bus.m_frame_valid, 1);
    chk("t6_busy_pre", busy, 1);
    rst = 1'b1;
    step(); step();
    chk("t6_valid_rst", bus.m_frame_valid, 0);
    chk("t6_busy_rst", busy, 0);
    chk("t6_req_ready_rst", bus.s_req_ready, 0);
    rst = 1'b0;
    bus.m_frame_ready = 1'b1;
    step();
    chk("t6_req_ready_post", bus.s_req_ready, 1);
    repeat (30) step();
    chk("t6_no_pulses", (done_cnt - bd) + (err_cnt - be), 0);
    chk("t6_no_frames", hs_total - bh, 0);
    exp_q.push_back(mk_req(32'h0A00_0033, MAC0, IP0));
    lookup(32'h0A00_0033, acc);
    wait_hs("t6_new_frame", bh + 1, 10);
    chk("t6_new_load_cyc", hs_cyc[bh], acc + 1);
    resolve(32'h0A00_0033);
    step();
    chk("t6_new_done", done_cnt - bd, 1);

    repeat (3) step();
    chk("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/arp_tx_sched.md
# arp_tx_sched

Scheduler in front of the ARP frame transmitter. It shares the transmitter between two sources: ARP replies requested by the receive path, and ARP requests for one outstanding IP lookup. Replies have strict priority. Requests are retransmitted on an interval timer until the address resolves or the retries run out. Its output drives the ARP frame input (valid/ready plus parallel header fields) of the Ethernet-side ARP transmitter.

## Interface
- RETRY_COUNT, 4: total request transmissions per lookup (≥1)
- RETRY_INTERVAL, 1000: cycles from loading a request frame to its timeout (≥2)
- TIMER_WIDTH, 32: timer counter width; RETRY_INTERVAL must fit

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- local_mac  in  48  own MAC, sampled when a frame is loaded
- local_ip  in  32  own IP, sampled when a frame is loaded
- s_reply_valid  in  1  reply request
- s_reply_ready  out  1  reply accepted
- s_reply_tha  in  48  requester MAC
- s_reply_tpa  in  32  requester IP
- s_req_valid  in  1  lookup request
- s_req_ready  out  1  lookup accepted
- s_req_ip  in  32  IP to resolve
- s_resolved_valid  in  1  cache-write strobe from the receive path
- s_resolved_ip  in  32  IP just resolved
- m_frame_valid  out  1  frame valid to the transmitter
- m_frame_ready  in  1  transmitter ready
- m_eth_dest_mac, m_eth_src_mac  out  48  Ethernet header
- m_eth_type  out  16  always 0x0806
- m_arp_htype, m_arp_ptype, m_arp_oper  out  16  0x0001, 0x0800, 1 or 2
- m_arp_sha, m_arp_tha  out  48  ARP hardware addresses
- m_arp_spa, m_arp_tpa  out  32  ARP protocol addresses
- req_done  out  1  one-cycle pulse: lookup resolved
- req_error  out  1  one-cycle pulse: lookup timed out
- busy  out  1  lookup pending or frame valid

## Operation
- Output register: free = !m_frame_valid || m_frame_ready. Fields change only on load; valid stays high until handshake.
- s_reply_ready = free (combinational). On reply handshake, load a reply frame:
  - dest = tha = s_reply_tha, tpa = s_reply_tpa, oper = 2
  - src = sha = local_mac, spa = local_ip
- Lookup tracker state: pending, ip, send_due, retry_cnt, timer.
- s_req_ready = !pending (registered). On acceptance: pending = 1, ip latched, send_due = 1, retry_cnt = RETRY_COUNT.
- Request load, when send_due && free && !s_reply_valid:
  - dest = ff:ff:ff:ff:ff:ff, oper = 1, tha = 0, tpa = ip
  - src = sha = local_mac, spa = local_ip
  - send_due = 0, retry_cnt decrements, timer = RETRY_INTERVAL-1
- Timer decrements while pending && !send_due. At 0: if retry_cnt == 0, pulse req_error and clear pending; else set send_due.
- Resolution: s_resolved_valid && pending && s_resolved_ip == ip pulses req_done and clears pending and send_due. An already-loaded frame still completes.
- Simultaneous events:
  - Resolution and timer expiry in the same cycle: resolution wins; no error.
  - Reply and due request both ready to load: the reply loads, the request waits.

## Timing
- Reset values: m_frame_valid 0; all field outputs 0; s_req_ready 0 in the reset cycle, then 1; req_done 0, req_error 0, busy 0.
- Latency:
  - Reply handshake to m_frame_valid high: 1 cycle.
  - Lookup accept to request m_frame_valid high: 2 cycles, if no reply competes.
  - req_done / req_error: 1 cycle after the cause, lasting exactly 1 cycle.
- Mid-operation reset: drops the pending lookup and the valid frame; no pulses.
- Back-to-back frames with m_frame_ready held high have no bubble.

## Configuration
- ARP_SCHED_RETRY_EN defined: up to RETRY_COUNT transmissions per lookup, as above.
- Not defined: retry_cnt is forced to 0, so there is exactly one transmission. req_error fires RETRY_INTERVAL cycles after that request loads unless resolved first. RETRY_COUNT is ignored.

## Test plan
- Lookup 10.0.0.5, never resolved, RETRY_COUNT=3, RETRY_INTERVAL=20, ready high, macro defined -> 3 broadcast frames with oper=1 and tpa=0x0A000005, loaded 20 cycles apart; req_error pulses once, 20 cycles after the third load.
- Same lookup; s_resolved_ip=0x0A000005 pulsed 5 cycles after the first frame -> req_done once, no further frames, no req_error, s_req_ready high the next cycle.
- Reply request (tha 02:00:00:00:00:01) asserted in the same cycle a request becomes due -> reply frame (oper=2) first, request frame on the next handshake.
- m_frame_ready held low 50 cycles during a reply -> all fields stable while m_frame_valid is high; s_reply_ready low until the handshake.
- Resolution and timer expiry in the same cycle with retry_cnt=0 -> req_done only.
- Macro undefined, RETRY_INTERVAL=20, no resolution -> exactly one request frame; req_error 20 cycles after load.
- rst asserted while a lookup is pending -> m_frame_valid=0, busy=0, no pulses; a new lookup is accepted after reset.
